// File: rtl/morse_key_decoder.sv
// Morse key decoder: sync + debounce a raw key, time marks/spaces in units, emit one ASCII byte per character or word gap.
// Latency: key->key_level 2+DEBOUNCE_CYCLES, release->char 1+3 units, ->space 1+7 units; no backpressure, char_valid is a one-shot strobe.
module morse_key_decoder #(
  parameter int UNIT_CYCLES     = 25_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  output logic       key_level,
  output logic       char_valid,
  output logic [7:0] char_ascii,
  output logic       char_err,
  output logic [2:0] elem_count
);

  localparam int SUB_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, WGAP} state_t;

  state_t            state, state_nxt;
  logic              key_s1, key_s2;
  logic [DB_W-1:0]   db_cnt;
  logic [SUB_W-1:0]  sub_cnt;
  logic [3:0]        dur;
  logic [4:0]        pat;
  logic [2:0]        len;
  logic              ovf;
  logic              unit_wrap, dur_to3, dur_to4;
  logic              end_mark, emit_char, emit_space;
  logic [7:0]        lk_ascii;

  // Keyed on {len, pat}; pattern bits are first element at bit len-1, dot=0, dash=1.
  function automatic logic [7:0] morse_lookup(input logic [2:0] l, input logic [4:0] p);
    case ({l, p})
      {3'd2, 5'b00001}: return 8'h41; // A
      {3'd4, 5'b01000}: return 8'h42; // B
      {3'd4, 5'b01010}: return 8'h43; // C
      {3'd3, 5'b00100}: return 8'h44; // D
      {3'd1, 5'b00000}: return 8'h45; // E
      {3'd4, 5'b00010}: return 8'h46; // F
      {3'd3, 5'b00110}: return 8'h47; // G
      {3'd4, 5'b00000}: return 8'h48; // H
      {3'd2, 5'b00000}: return 8'h49; // I
      {3'd4, 5'b00111}: return 8'h4A; // J
      {3'd3, 5'b00101}: return 8'h4B; // K
      {3'd4, 5'b00100}: return 8'h4C; // L
      {3'd2, 5'b00011}: return 8'h4D; // M
      {3'd2, 5'b00010}: return 8'h4E; // N
      {3'd3, 5'b00111}: return 8'h4F; // O
      {3'd4, 5'b00110}: return 8'h50; // P
      {3'd4, 5'b01101}: return 8'h51; // Q
      {3'd3, 5'b00010}: return 8'h52; // R
      {3'd3, 5'b00000}: return 8'h53; // S
      {3'd1, 5'b00001}: return 8'h54; // T
      {3'd3, 5'b00001}: return 8'h55; // U
      {3'd4, 5'b00001}: return 8'h56; // V
      {3'd3, 5'b00011}: return 8'h57; // W
      {3'd4, 5'b01001}: return 8'h58; // X
      {3'd4, 5'b01011}: return 8'h59; // Y
      {3'd4, 5'b01100}: return 8'h5A; // Z
      {3'd5, 5'b11111}: return 8'h30;
      {3'd5, 5'b01111}: return 8'h31;
      {3'd5, 5'b00111}: return 8'h32;
      {3'd5, 5'b00011}: return 8'h33;
      {3'd5, 5'b00001}: return 8'h34;
      {3'd5, 5'b00000}: return 8'h35;
      {3'd5, 5'b10000}: return 8'h36;
      {3'd5, 5'b11000}: return 8'h37;
      {3'd5, 5'b11100}: return 8'h38;
      {3'd5, 5'b11110}: return 8'h39;
      default:          return 8'h00;
    endcase
  endfunction

  assign unit_wrap  = (sub_cnt == SUB_W'(UNIT_CYCLES - 1));
  assign dur_to3    = unit_wrap && (dur == 4'd2);
  assign dur_to4    = unit_wrap && (dur == 4'd3);
  assign lk_ascii   = morse_lookup(len, pat);
  assign elem_count = len;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The FSM follows key_level itself, so "rise" and "fall" reduce to level tests per state.
  always_comb begin
    state_nxt  = state;
    end_mark   = 1'b0;
    emit_char  = 1'b0;
    emit_space = 1'b0;
    case (state)
      IDLE:  if (key_level) state_nxt = MARK;
      MARK:  if (!key_level) begin
               end_mark  = 1'b1;
               state_nxt = SPACE;
             end
      SPACE: if (dur_to3) begin
               emit_char = 1'b1;
               state_nxt = key_level ? MARK : WGAP;
             end else if (key_level) begin
               state_nxt = MARK;
             end
      WGAP:  if (dur_to4) begin
               emit_space = 1'b1;
               state_nxt  = key_level ? MARK : IDLE;
             end else if (key_level) begin
               state_nxt = MARK;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_s1     <= 1'b0;
      key_s2     <= 1'b0;
      db_cnt     <= '0;
      key_level  <= 1'b0;
      sub_cnt    <= '0;
      dur        <= 4'd0;
      pat        <= 5'd0;
      len        <= 3'd0;
      ovf        <= 1'b0;
      char_valid <= 1'b0;
      char_ascii <= 8'h00;
      char_err   <= 1'b0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;

      if (key_s2 == key_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_level <= key_s2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end

      if (state_nxt != state) begin
        sub_cnt <= '0;
        dur     <= 4'd0;
      end else if (unit_wrap) begin
        sub_cnt <= '0;
        if (dur != 4'd15) dur <= dur + 4'd1;
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end

      if (emit_char) begin
        pat <= 5'd0;
        len <= 3'd0;
        ovf <= 1'b0;
      end else if (end_mark) begin
        if (len == 3'd5) begin
          ovf <= 1'b1;
        end else begin
          pat <= {pat[3:0], (dur >= 4'd2)};
          len <= len + 3'd1;
        end
      end

      char_valid <= emit_char | emit_space;
      if (emit_char) begin
        char_ascii <= (ovf || lk_ascii == 8'h00) ? 8'h3F : lk_ascii;
        char_err   <= ovf || (lk_ascii == 8'h00);
      end else if (emit_space) begin
        char_ascii <= 8'h20;
        char_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Directed bench for morse_key_decoder with UNIT_CYCLES=4, DEBOUNCE_CYCLES=2.
module tb_morse_key_decoder;

  localparam int UNIT = 4;
  localparam int DEB  = 2;
  localparam int CHAR_LAT = 2 + DEB + 1 + 3 * UNIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key = 1'b0;
  logic       key_level;
  logic       char_valid;
  logic [7:0] char_ascii;
  logic       char_err;
  logic [2:0] elem_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int c0;

  logic [8:0] q_dat[$];
  int         q_cyc[$];
  logic       q_kl[$];
  logic [2:0] max_ec;
  logic       kl_seen;

  morse_key_decoder #(.UNIT_CYCLES(UNIT), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key        (key),
    .key_level  (key_level),
    .char_valid (char_valid),
    .char_ascii (char_ascii),
    .char_err   (char_err),
    .elem_count (elem_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (char_valid) begin
      q_dat.push_back({char_err, char_ascii});
      q_cyc.push_back(cyc);
      q_kl.push_back(key_level);
    end
    if (elem_count > max_ec) max_ec = elem_count;
    if (key_level) kl_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    key = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    q_dat.delete();
    q_cyc.delete();
    q_kl.delete();
    max_ec  = 3'd0;
    kl_seen = 1'b0;
  endtask

  function automatic logic [8:0] qd(input int i);
    return (i < q_dat.size()) ? q_dat[i] : 9'h1FF;
  endfunction

  function automatic int qc(input int i);
    return (i < q_cyc.size()) ? q_cyc[i] : -1000;
  endfunction

  function automatic logic qk(input int i);
    return (i < q_kl.size()) ? q_kl[i] : 1'bx;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_key_level"},  key_level,  0);
    check({tag, "_char_valid"}, char_valid, 0);
    check({tag, "_char_ascii"}, char_ascii, 0);
    check({tag, "_char_err"},   char_err,   0);
    check({tag, "_elem_count"}, elem_count, 0);
  endtask

  initial begin
    clear_log();
    rst_n = 1'b0;
    key   = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // "A" = .-
    clear_log();
    hold(1, 4); hold(0, 4); hold(1, 12);
    c0 = cyc;
    hold(0, 40);
    check("A_count",     q_dat.size(), 2);
    check("A_char",      qd(0), 9'h041);
    check("A_space",     qd(1), 9'h020);
    check("A_char_lat",  qc(0) - c0, CHAR_LAT);
    check("A_space_lat", qc(1) - qc(0), 4 * UNIT);
    check("A_ascii_held", char_ascii, 8'h20);
    check("A_elem_idle", elem_count, 0);

    // "SOS" with 12-cycle letter gaps
    clear_log();
    for (int i = 0; i < 3; i++) begin hold(1, 4);  hold(0, (i == 2) ? 12 : 4); end
    for (int i = 0; i < 3; i++) begin hold(1, 12); hold(0, (i == 2) ? 12 : 4); end
    for (int i = 0; i < 3; i++) begin hold(1, 4);  hold(0, (i == 2) ? 40 : 4); end
    check("SOS_count", q_dat.size(), 4);
    check("SOS_s1",    qd(0), 9'h053);
    check("SOS_o",     qd(1), 9'h04F);
    check("SOS_s2",    qd(2), 9'h053);
    check("SOS_space", qd(3), 9'h020);

    // six dots overflows the pattern
    clear_log();
    for (int i = 0; i < 6; i++) begin hold(1, 4); hold(0, (i == 5) ? 40 : 4); end
    check("ovf_count", q_dat.size(), 2);
    check("ovf_char",  qd(0), 9'h13F);
    check("ovf_peak",  max_ec, 5);
    check("ovf_space", qd(1), 9'h020);

    // single-cycle glitches while idle
    clear_log();
    for (int i = 0; i < 5; i++) begin hold(1, 1); hold(0, 3); end
    hold(0, 10);
    check("glitch_level",   kl_seen, 0);
    check("glitch_strobes", q_dat.size(), 0);

    // reset mid-MARK of the second element, then "E"
    clear_log();
    hold(1, 4); hold(0, 4);
    key = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_elem", elem_count, 1);
    rst_n = 1'b0;
    key   = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst");
    rst_n = 1'b1;
    hold(0, 10); hold(1, 4); hold(0, 40);
    check("rst_count", q_dat.size(), 2);
    check("rst_char",  qd(0), 9'h045);
    check("rst_space", qd(1), 9'h020);

    // "E" then a press landing on the letter-gap boundary, then a dash
    clear_log();
    hold(1, 4);
    c0 = cyc;
    hold(0, 12); hold(1, 12); hold(0, 40);
    check("sim_count",  q_dat.size(), 3);
    check("sim_e",      qd(0), 9'h045);
    check("sim_e_lat",  qc(0) - c0, CHAR_LAT);
    check("sim_e_key",  qk(0), 1);
    check("sim_t",      qd(1), 9'h054);
    check("sim_space",  qd(2), 9'h020);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
